// File: rtl/ola_output_stage_if.sv
// Interface for the overlap-add output stage. It carries the frame input, the
// audio-rate strobe, and the registered output pulses.
interface ola_output_stage_if #(
    parameter int fxp_size = 32
);
    logic                i_valid;
    logic [fxp_size-1:0] i_sample;
    logic                i_sample_strobe;
    logic                o_valid;
    logic [fxp_size-1:0] o_sample;
    logic                o_underrun;
    logic                o_overrun;

    modport master (
        output i_valid, i_sample, i_sample_strobe,
        input  o_valid, o_sample, o_underrun, o_overrun
    );

    modport slave (
        input  i_valid, i_sample, i_sample_strobe,
        output o_valid, o_sample, o_underrun, o_overrun
    );
endinterface

// File: rtl/ola_output_stage.sv
// Overlap-add of 2*window_size IFFT bursts into a ping-pong output buffer that is
// drained one sample per audio strobe. The interface fxp_size must match this module's.
module ola_output_stage #(
    parameter int fxp_size    = 32,
    parameter int window_size = 64
) (
    input logic               clk,
    input logic               rst,
    ola_output_stage_if.slave bus
);
    localparam int IDX_W  = $clog2(2 * window_size);
    localparam int RIDX_W = $clog2(window_size);
    localparam logic [IDX_W-1:0]  IN_LAST = IDX_W'(2 * window_size - 1);
    localparam logic [RIDX_W-1:0] R_LAST  = RIDX_W'(window_size - 1);

    typedef enum logic [1:0] {IN_IDLE, IN_ACCEPT, IN_DROP} in_state_t;
    typedef enum logic {OUT_PRIME, OUT_RUN} out_state_t;

    logic [fxp_size-1:0] tail_q [window_size];
    logic [fxp_size-1:0] bank_q [2][window_size];

    in_state_t           in_state_q, in_state_d;
    out_state_t          out_state_q, out_state_d;
    logic [IDX_W-1:0]    in_idx_q, in_idx_d;
    logic [RIDX_W-1:0]   r_idx_q, r_idx_d;
    logic                wbank_q, wbank_d;
    logic                rbank_q, rbank_d;
    logic [1:0]          full_q, full_d;
    logic                o_valid_q, o_valid_d;
    logic [fxp_size-1:0] o_sample_q, o_sample_d;
    logic                o_underrun_q, o_underrun_d;
    logic                o_overrun_q, o_overrun_d;

    logic                take, drop;
    logic                bank_we, tail_we;
    logic [RIDX_W-1:0]   wr_addr;
    logic [fxp_size-1:0] sum_sat;

    function automatic logic [fxp_size-1:0] sat_add(input logic [fxp_size-1:0] a,
                                                    input logic [fxp_size-1:0] b);
        logic [fxp_size:0] sum;
        sum = {a[fxp_size-1], a} + {b[fxp_size-1], b};
        // Sign bits disagreeing means the true sum left the representable range.
        if (sum[fxp_size] != sum[fxp_size-1])
            sat_add = sum[fxp_size] ? {1'b1, {(fxp_size-1){1'b0}}}
                                    : {1'b0, {(fxp_size-1){1'b1}}};
        else
            sat_add = sum[fxp_size-1:0];
    endfunction

    always_comb begin
        in_state_d   = in_state_q;
        out_state_d  = out_state_q;
        in_idx_d     = in_idx_q;
        r_idx_d      = r_idx_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        full_d       = full_q;
        o_valid_d    = 1'b0;
        o_sample_d   = o_sample_q;
        o_underrun_d = 1'b0;
        o_overrun_d  = 1'b0;
        take         = 1'b0;
        drop         = 1'b0;

        case (in_state_q)
            IN_IDLE: begin
                if (bus.i_valid) begin
                    if (!full_q[wbank_q]) begin
                        take       = 1'b1;
                        in_state_d = IN_ACCEPT;
                    end else begin
                        drop        = 1'b1;
                        in_state_d  = IN_DROP;
                        o_overrun_d = 1'b1;
                    end
                end
            end
            IN_ACCEPT: take = bus.i_valid;
            IN_DROP:   drop = bus.i_valid;
            default:   in_state_d = IN_IDLE;
        endcase

        if (take || drop) begin
            if (in_idx_q == IN_LAST) begin
                in_idx_d   = '0;
                in_state_d = IN_IDLE;
                if (take) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                end
            end else begin
                in_idx_d = in_idx_q + 1'b1;
            end
        end

        // First half overlaps with the stored tail; second half becomes the new tail.
        wr_addr = in_idx_q[RIDX_W-1:0];
        bank_we = take && !in_idx_q[IDX_W-1];
        tail_we = take && in_idx_q[IDX_W-1];
        sum_sat = sat_add(bus.i_sample, tail_q[wr_addr]);

        // A strobe arriving as the first bank fills is served immediately.
        if (out_state_q == OUT_PRIME && full_q[rbank_q])
            out_state_d = OUT_RUN;

        if (bus.i_sample_strobe && (out_state_q == OUT_RUN || full_q[rbank_q])) begin
            o_valid_d = 1'b1;
            if (full_q[rbank_q]) begin
                o_sample_d = bank_q[rbank_q][r_idx_q];
                if (r_idx_q == R_LAST) begin
                    r_idx_d         = '0;
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                end else begin
                    r_idx_d = r_idx_q + 1'b1;
                end
            end else begin
                o_sample_d   = '0;
                o_underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state_q   <= IN_IDLE;
            out_state_q  <= OUT_PRIME;
            in_idx_q     <= '0;
            r_idx_q      <= '0;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            full_q       <= '0;
            o_valid_q    <= 1'b0;
            o_sample_q   <= '0;
            o_underrun_q <= 1'b0;
            o_overrun_q  <= 1'b0;
        end else begin
            in_state_q   <= in_state_d;
            out_state_q  <= out_state_d;
            in_idx_q     <= in_idx_d;
            r_idx_q      <= r_idx_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            full_q       <= full_d;
            o_valid_q    <= o_valid_d;
            o_sample_q   <= o_sample_d;
            o_underrun_q <= o_underrun_d;
            o_overrun_q  <= o_overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < window_size; i++) begin
                tail_q[i]    <= '0;
                bank_q[0][i] <= '0;
                bank_q[1][i] <= '0;
            end
        end else begin
            if (tail_we)
                tail_q[wr_addr] <= bus.i_sample;
            if (bank_we)
                bank_q[wbank_q][wr_addr] <= sum_sat;
        end
    end

    assign bus.o_valid    = o_valid_q;
    assign bus.o_sample   = o_sample_q;
    assign bus.o_underrun = o_underrun_q;
    assign bus.o_overrun  = o_overrun_q;
endmodule

// File: tb/tb_ola_output_stage.sv
// Self-checking bench for ola_output_stage: directed frame sequences, a saturation
// vector table and a randomized phase, all checked against a queue-based model.
module tb_ola_output_stage;
    localparam int FXP = 32;
    localparam int WIN = 64;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ola_output_stage_if #(.fxp_size(FXP)) bus ();
    ola_output_stage #(.fxp_size(FXP), .window_size(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: completed frames sit in a flat FIFO of samples.
    logic [FXP-1:0] m_tail [WIN];
    logic [FXP-1:0] m_frame [WIN];
    logic [FXP-1:0] m_ready [$];
    int             m_pos;
    bit             m_dropping;
    bit             m_primed;
    bit             exp_valid, exp_under, exp_over;
    logic [FXP-1:0] exp_sample;

    logic [FXP-1:0] cap [$];
    logic [FXP-1:0] fr [2*WIN];
    int             ov_count;
    int             out_count;

    typedef struct {
        logic [FXP-1:0] tail_val;
        logic [FXP-1:0] head_val;
        logic [FXP-1:0] exp_val;
    } sat_vec_t;
    sat_vec_t tbl [8];

    task automatic chk(input string name, input logic [FXP-1:0] act, input logic [FXP-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [FXP-1:0] ref_sat(input logic [FXP-1:0] a, input logic [FXP-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return FXP'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WIN; i++) begin
            m_tail[i]  = '0;
            m_frame[i] = '0;
        end
        m_ready.delete();
        m_pos      = 0;
        m_dropping = 0;
        m_primed   = 0;
    endtask

    task automatic model_cycle(input bit v, input logic [FXP-1:0] s, input bit st);
        int full_banks;
        full_banks = (m_ready.size() + WIN - 1) / WIN;
        if (m_ready.size() > 0) m_primed = 1;
        exp_valid = 0;
        exp_under = 0;
        exp_over  = 0;
        if (st && m_primed) begin
            exp_valid = 1;
            if (m_ready.size() > 0) begin
                exp_sample = m_ready.pop_front();
            end else begin
                exp_sample = '0;
                exp_under  = 1;
            end
        end
        if (v) begin
            if (m_pos == 0) begin
                m_dropping = (full_banks >= 2);
                exp_over   = m_dropping;
            end
            if (!m_dropping) begin
                if (m_pos < WIN) m_frame[m_pos] = ref_sat(s, m_tail[m_pos]);
                else             m_tail[m_pos-WIN] = s;
            end
            if (m_pos == 2*WIN-1) begin
                if (!m_dropping)
                    for (int j = 0; j < WIN; j++) m_ready.push_back(m_frame[j]);
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic step(input bit v, input logic [FXP-1:0] s, input bit st);
        bus.i_valid         = v;
        bus.i_sample        = s;
        bus.i_sample_strobe = st;
        model_cycle(v, s, st);
        @(posedge clk);
        #1;
        bus.i_valid         = 1'b0;
        bus.i_sample_strobe = 1'b0;
        chk("o_valid", FXP'(bus.o_valid), FXP'(exp_valid));
        chk("o_underrun", FXP'(bus.o_underrun), FXP'(exp_under));
        chk("o_overrun", FXP'(bus.o_overrun), FXP'(exp_over));
        if (exp_valid) chk("o_sample", bus.o_sample, exp_sample);
        if (bus.o_overrun) ov_count++;
        if (bus.o_valid) begin
            cap.push_back(bus.o_sample);
            out_count++;
            $display("OUT %0d sample=%h underrun=%0b", out_count, bus.o_sample, bus.o_underrun);
        end
    endtask

    task automatic send_frame(input int gap_max);
        for (int k = 0; k < 2*WIN; k++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int j = 0; j < g; j++) step(0, '0, 0);
            step(1, fr[k], 0);
        end
    endtask

    task automatic drain(input int n, input int spacing);
        cap.delete();
        for (int i = 0; i < n; i++) begin
            step(0, '0, 1);
            for (int j = 0; j < spacing; j++) step(0, '0, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_o_valid"}, FXP'(bus.o_valid), '0);
        chk({tag, "_o_sample"}, bus.o_sample, '0);
        chk({tag, "_o_underrun"}, FXP'(bus.o_underrun), '0);
        chk({tag, "_o_overrun"}, FXP'(bus.o_overrun), '0);
    endtask

    task automatic chk_cap(input string name, input int idx, input logic [FXP-1:0] req);
        if (cap.size() > idx) chk(name, cap[idx], req);
        else                  chk({name, "_missing"}, FXP'(cap.size()), FXP'(idx + 1));
    endtask

    initial begin
        tbl[0] = '{32'h7FFFFFF0, 32'h00000100, 32'h7FFFFFFF};
        tbl[1] = '{32'h80000010, 32'hFFFFFF00, 32'h80000000};
        tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF};
        tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[4] = '{32'h7FFFFF00, 32'h000000FF, 32'h7FFFFFFF};
        tbl[5] = '{32'h00000005, 32'hFFFFFFFD, 32'h00000002};
        tbl[6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFC};
        tbl[7] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        bus.i_valid = 1'b0; bus.i_sample = '0; bus.i_sample_strobe = 1'b0;
        ov_count = 0; out_count = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_initial");
        rst = 1'b1;

        // Make o_sample non-zero, then reset in the middle of a frame's second half.
        for (int k = 0; k < 2*WIN; k++) fr[k] = FXP'(500 + k);
        send_frame(1);
        drain(2, 2);
        for (int k = 0; k < 100; k++) step(1, FXP'(9000 + k), 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_midframe");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Frame 1 ramps with zero tail; frame 2 is all ones on top of the ramp tail.
        for (int k = 0; k < 2*WIN; k++) fr[k] = FXP'(k);
        send_frame(2);
        step(0, '0, 0);
        drain(WIN, 3);
        for (int k = 0; k < WIN; k++) chk_cap("frame1_out", k, FXP'(k));
        for (int k = 0; k < 2*WIN; k++) fr[k] = FXP'(1);
        send_frame(0);
        drain(WIN, 2);
        for (int k = 0; k < WIN; k++) chk_cap("frame2_out", k, FXP'(65 + k));

        // Saturation table: tails planted by one frame, heads added by the next.
        for (int k = 0; k < 2*WIN; k++) fr[k] = '0;
        for (int i = 0; i < 8; i++) fr[WIN + i] = tbl[i].tail_val;
        send_frame(1);
        drain(WIN, 2);
        for (int k = 0; k < 2*WIN; k++) fr[k] = '0;
        for (int i = 0; i < 8; i++) fr[i] = tbl[i].head_val;
        send_frame(1);
        drain(WIN, 2);
        for (int i = 0; i < 8; i++) chk_cap("sat_vec", i, tbl[i].exp_val);

        // Underrun with no frame pending, then resume at r_idx 0.
        step(0, '0, 1);
        chk("underrun_valid", FXP'(bus.o_valid), FXP'(1));
        chk("underrun_sample", bus.o_sample, '0);
        chk("underrun_flag", FXP'(bus.o_underrun), FXP'(1));
        step(0, '0, 0);
        chk("underrun_single_cycle", FXP'(bus.o_underrun), '0);
        for (int k = 0; k < 2*WIN; k++) fr[k] = (k < WIN) ? FXP'(3 * k) : '0;
        send_frame(0);
        drain(WIN, 2);
        chk_cap("resume_first", 0, '0);
        chk_cap("resume_last", WIN - 1, FXP'(189));

        // Overrun: three frames back to back, the third is dropped on its first sample.
        for (int k = 0; k < 2*WIN; k++) fr[k] = FXP'(1000 + k);
        send_frame(2);
        for (int k = 0; k < 2*WIN; k++) fr[k] = FXP'(2000 + k);
        send_frame(2);
        ov_count = 0;
        step(1, FXP'(5000), 0);
        chk("overrun_first_sample", FXP'(bus.o_overrun), FXP'(1));
        for (int k = 1; k < 2*WIN; k++) begin
            if ((k % 5) == 0) step(0, '0, 0);
            step(1, FXP'(5000 + k), 0);
        end
        chk("overrun_count", FXP'(ov_count), FXP'(1));
        drain(2*WIN, 2);
        for (int k = 0; k < WIN; k++) chk_cap("overrun_frameA", k, FXP'(1000 + k));
        for (int k = 0; k < WIN; k++) chk_cap("overrun_frameB", WIN + k, FXP'(3064 + 2*k));
        for (int k = 0; k < 2*WIN; k++) fr[k] = '0;
        send_frame(1);
        drain(WIN, 2);
        for (int k = 0; k < WIN; k++) chk_cap("tail_kept", k, FXP'(2064 + k));

        // Randomized traffic in three rate regimes to mix overruns and underruns.
        for (int seg = 0; seg < 3; seg++) begin
            int vp, sgap, since;
            case (seg)
                0:       begin vp = 40; sgap = 3;  end
                1:       begin vp = 8;  sgap = 2;  end
                default: begin vp = 90; sgap = 12; end
            endcase
            since = 0;
            for (int c = 0; c < 1500; c++) begin
                bit v, st;
                logic [FXP-1:0] s;
                v = ($urandom_range(99, 0) < vp);
                case ($urandom_range(2, 0))
                    0:       s = $urandom;
                    1:       s = 32'h7FFFFF00 | FXP'($urandom_range(255, 0));
                    default: s = 32'h80000000 | FXP'($urandom_range(255, 0));
                endcase
                st = (since >= sgap) && ($urandom_range(1, 0) == 1);
                since = st ? 0 : since + 1;
                step(v, s, st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ola_output_stage.md
Name: ola_output_stage

Overview:
- Downstream of the FFT-convolution IR filter; consumes its inverse-FFT real-output bursts of 2*window_size samples per frame.
- Performs overlap-add: first half of each frame is added to the stored second half of the previous frame.
- Emits the resulting window_size samples at audio rate, one per i_sample_strobe, through a ping-pong output buffer.
- Decouples the bursty filter clock domain timing from the steady codec sample rate.

Parameters:
- fxp_size, 32, signed fixed-point sample width (two's complement).
- window_size, 64, hop size; frame length is 2*window_size; power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- i_valid  in  1  one frame sample present on i_sample this cycle.
- i_sample  in  fxp_size  IFFT real output; frame position implied by count of accepted i_valid.
- i_sample_strobe  in  1  single-cycle audio-rate tick requesting one output sample.
- o_valid  out  1  single-cycle pulse, o_sample updated.
- o_sample  out  fxp_size  output sample, registered.
- o_underrun  out  1  single-cycle pulse: strobe served with silence.
- o_overrun  out  1  single-cycle pulse: incoming frame dropped.

Behaviour:
- Storage: tail[window_size], bank0[window_size], bank1[window_size], all fxp_size; full flags full0/full1; pointers wbank, rbank, in_idx (log2(2*window_size) bits), r_idx (log2(window_size) bits).
- Reset (rst low, async): all outputs 0; tail, banks, flags, pointers, in_idx, r_idx cleared; input FSM IDLE; output FSM PRIME. Reset mid-frame discards the partial frame; next i_valid after release is position 0.
- Input FSM: IDLE, ACCEPT, DROP.
  - IDLE + i_valid: if full[wbank] = 0, go ACCEPT and process the sample as position 0; otherwise go DROP, pulse o_overrun, discard the sample.
  - ACCEPT, position p = in_idx:
    - p < window_size: bank[wbank][p] <= sat(i_sample + tail[p]).
    - p >= window_size: tail[p-window_size] <= i_sample. The read of tail[p] always precedes its overwrite.
  - DROP: samples counted but discarded; tail and banks untouched.
  - in_idx increments on every accepted i_valid. Gaps in i_valid hold the state.
  - At position 2*window_size-1: in_idx wraps to 0 and the FSM returns to IDLE. From ACCEPT, also set full[wbank] and toggle wbank.
- Saturation: the sum is computed at fxp_size+1 bits and clamped to [-2^(fxp_size-1), 2^(fxp_size-1)-1]. No scaling.
- Output FSM: PRIME, RUN.
  - PRIME: strobes ignored (o_valid stays 0) until full[rbank] = 1, then RUN.
  - RUN, on strobe with full[rbank] = 1:
    - o_sample <= bank[rbank][r_idx]; o_valid pulses next cycle; r_idx increments.
    - At r_idx = window_size-1: clear full[rbank], toggle rbank, r_idx wraps to 0.
  - RUN, on strobe with full[rbank] = 0: o_sample <= 0, o_valid and o_underrun pulse; r_idx unchanged.
- Latency: strobe at cycle t gives o_valid/o_sample at t+1. The first output of a frame is available on the first strobe at least one cycle after the frame's last sample.
- Simultaneous events:
  - Set of full[wbank] and clear of full[rbank] in the same cycle always hit different banks (writes to a full bank are dropped); both take effect.
  - i_valid and i_sample_strobe in the same cycle are handled independently.
- Strobes closer than 1 cycle apart are impossible; the strobe period is far above 1 cycle.
- Requirement: RTL arrays may map to LUTRAM, but the read-before-write order within ACCEPT must be preserved.

Test Plan:
- Reset check: drive rst low mid-frame, then release -> o_valid=0, o_sample=0, o_underrun=0, o_overrun=0; next frame starts at position 0.
- First frame, i_sample=k for k=0..127 (tail zero), then 64 strobes -> outputs 0,1,...,63, each one cycle after its strobe; no o_underrun.
- Second frame all 1 -> outputs 65,66,...,128 (tail 64+k plus 1).
- Saturation: tail entry 0x7FFFFFF0 plus 0x00000100 -> 0x7FFFFFFF; tail 0x80000010 plus 0xFFFFFF00 -> 0x80000000.
- Underrun: in RUN, drain a bank, then strobe with no frame pending -> o_sample=0, o_valid=1, o_underrun=1 for one cycle; next full frame resumes output at r_idx 0.
- Overrun: three frames back-to-back with no strobes -> o_overrun pulses on the third frame's first sample. The third frame is discarded and the tail is unchanged. The subsequent 128 strobes output frames 1 and 2 only. Gaps inserted in i_valid do not change results.
